// File: rtl/sprite_shifter_pkg.sv
// Shared PPU sprite definitions.
// Purpose: slot count, OAM attribute bit positions, the per-slot state
//          record and a bit-reversal helper used for horizontal flip.
// Ports:   none (package).
package sprite_shifter_pkg;

    localparam int SLOT_COUNT = 8;
    localparam int SLOT_IDX_W = 3;

    // OAM attribute byte layout
    localparam int ATTR_PAL_LO = 0;
    localparam int ATTR_PAL_HI = 1;
    localparam int ATTR_PRIO   = 5;
    localparam int ATTR_HFLIP  = 6;

    typedef struct packed {
        logic [7:0] pat_lo;
        logic [7:0] pat_hi;
        logic [1:0] pal;
        logic       prio;
        logic [7:0] x_cnt;
    } slot_t;

    // Empty slot: no pattern, counter at zero, sprite behind background.
    localparam slot_t SLOT_CLEAR = '{
        pat_lo: 8'h00,
        pat_hi: 8'h00,
        pal:    2'b00,
        prio:   1'b1,
        x_cnt:  8'h00
    };

    function automatic logic [7:0] bit_reverse8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_shifter_slot.sv
// One sprite output slot.
// Purpose: holds one sprite's two pattern bitplanes, palette, priority and
//          X down-counter; counts down to the sprite's X position, then
//          shifts the pattern out MSB-first, one pixel per shifting strobe.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   clear              empty this slot
//   load               write this slot (wins over clear and shift)
//   shift              dot strobe while the line is visible
//   pat_lo, pat_hi     pattern bitplanes 0/1, bit 7 = leftmost pixel
//   pal, prio, hflip   decoded attribute fields
//   x                  sprite X position
//   pixel              {pal, plane1, plane0} when active, else 0
//   prio_out           stored priority bit
module sprite_slot
    import sprite_shifter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] pat_lo,
    input  logic [7:0] pat_hi,
    input  logic [1:0] pal,
    input  logic       prio,
    input  logic       hflip,
    input  logic [7:0] x,
    output logic [3:0] pixel,
    output logic       prio_out
);

    slot_t slot_reg;
    slot_t slot_next;

    always_comb begin
        slot_next = slot_reg;
        if (load) begin
            // Flip is resolved at load time so the shifter always emits bit 7.
            slot_next.pat_lo = hflip ? bit_reverse8(pat_lo) : pat_lo;
            slot_next.pat_hi = hflip ? bit_reverse8(pat_hi) : pat_hi;
            slot_next.pal    = pal;
            slot_next.prio   = prio;
            slot_next.x_cnt  = x;
        end else if (clear) begin
            slot_next = SLOT_CLEAR;
        end else if (shift) begin
            if (slot_reg.x_cnt != 8'h00) begin
                slot_next.x_cnt = slot_reg.x_cnt - 8'h01;
            end else begin
                // Zero fill: after eight shifts the slot goes transparent.
                slot_next.pat_lo = {slot_reg.pat_lo[6:0], 1'b0};
                slot_next.pat_hi = {slot_reg.pat_hi[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_reg <= SLOT_CLEAR;
        end else begin
            slot_reg <= slot_next;
        end
    end

    assign pixel    = (slot_reg.x_cnt == 8'h00)
                    ? {slot_reg.pal, slot_reg.pat_hi[7], slot_reg.pat_lo[7]}
                    : 4'b0000;
    assign prio_out = slot_reg.prio;

endmodule

// File: rtl/sprite_shifter.sv
// Eight-slot PPU sprite shifter.
// Purpose: eight independent sprite slots loaded one at a time during the
//          sprite fetch phase and shifted together during visible dots.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   pix_en                     one strobe per PPU dot
//   shift_active               high during visible dots 0..255
//   clear_all                  empty every slot
//   load_en, load_slot         write strobe and target slot
//   load_pat_lo, load_pat_hi   pattern bitplanes
//   load_attr                  OAM attribute byte
//   load_x                     sprite X position
//   sprite_pixel_0..7          per-slot {palette, plane1, plane0}
//   sprite_priority_buff       per-slot priority bits
module sprite_shifter
    import sprite_shifter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_en,
    input  logic                  shift_active,
    input  logic                  clear_all,
    input  logic                  load_en,
    input  logic [SLOT_IDX_W-1:0] load_slot,
    input  logic [7:0]            load_pat_lo,
    input  logic [7:0]            load_pat_hi,
    input  logic [7:0]            load_attr,
    input  logic [7:0]            load_x,
    output logic [3:0]            sprite_pixel_0,
    output logic [3:0]            sprite_pixel_1,
    output logic [3:0]            sprite_pixel_2,
    output logic [3:0]            sprite_pixel_3,
    output logic [3:0]            sprite_pixel_4,
    output logic [3:0]            sprite_pixel_5,
    output logic [3:0]            sprite_pixel_6,
    output logic [3:0]            sprite_pixel_7,
    output logic [SLOT_COUNT-1:0] sprite_priority_buff
);

    logic       shift;
    logic [3:0] pixel_arr [SLOT_COUNT];

    // Reserved attribute bits do not affect the shifter.
    logic unused_attr_bits;
    assign unused_attr_bits = ^{load_attr[7], load_attr[4:2]};

    assign shift = pix_en & shift_active;

    generate
        for (genvar gi = 0; gi < SLOT_COUNT; gi++) begin : g_slot
            logic load_sel;
            assign load_sel = load_en && (load_slot == SLOT_IDX_W'(gi));

            sprite_slot u_slot (
                .clk      (clk),
                .rst      (rst),
                .clear    (clear_all),
                .load     (load_sel),
                .shift    (shift),
                .pat_lo   (load_pat_lo),
                .pat_hi   (load_pat_hi),
                .pal      (load_attr[ATTR_PAL_HI:ATTR_PAL_LO]),
                .prio     (load_attr[ATTR_PRIO]),
                .hflip    (load_attr[ATTR_HFLIP]),
                .x        (load_x),
                .pixel    (pixel_arr[gi]),
                .prio_out (sprite_priority_buff[gi])
            );
        end
    endgenerate

    assign sprite_pixel_0 = pixel_arr[0];
    assign sprite_pixel_1 = pixel_arr[1];
    assign sprite_pixel_2 = pixel_arr[2];
    assign sprite_pixel_3 = pixel_arr[3];
    assign sprite_pixel_4 = pixel_arr[4];
    assign sprite_pixel_5 = pixel_arr[5];
    assign sprite_pixel_6 = pixel_arr[6];
    assign sprite_pixel_7 = pixel_arr[7];

endmodule

// File: tb/tb_sprite_shifter.sv
// Testbench for sprite_shifter: directed vector table, hand-written
// multi-cycle sequences and a randomized run, all checked against a
// per-slot model that tracks "dots left before the sprite starts" and
// "pixels already emitted" instead of a shift register.
module tb_sprite_shifter;

    logic       clk;
    logic       rst;
    logic       pix_en;
    logic       shift_active;
    logic       clear_all;
    logic       load_en;
    logic [2:0] load_slot;
    logic [7:0] load_pat_lo;
    logic [7:0] load_pat_hi;
    logic [7:0] load_attr;
    logic [7:0] load_x;
    logic [3:0] px [8];
    logic [7:0] prio_buff;

    sprite_shifter dut (
        .clk                  (clk),
        .rst                  (rst),
        .pix_en               (pix_en),
        .shift_active         (shift_active),
        .clear_all            (clear_all),
        .load_en              (load_en),
        .load_slot            (load_slot),
        .load_pat_lo          (load_pat_lo),
        .load_pat_hi          (load_pat_hi),
        .load_attr            (load_attr),
        .load_x               (load_x),
        .sprite_pixel_0       (px[0]),
        .sprite_pixel_1       (px[1]),
        .sprite_pixel_2       (px[2]),
        .sprite_pixel_3       (px[3]),
        .sprite_pixel_4       (px[4]),
        .sprite_pixel_5       (px[5]),
        .sprite_pixel_6       (px[6]),
        .sprite_pixel_7       (px[7]),
        .sprite_priority_buff (prio_buff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       clr;
        logic       ld;
        logic [2:0] slot;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] attr;
        logic [7:0] x;
        logic       pix;
        logic       act;
        logic [2:0] wslot;
        logic [3:0] exp_pix;
        logic [7:0] exp_prio;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: original (unflipped) bytes plus counters.
    logic [7:0] m_lo   [8];
    logic [7:0] m_hi   [8];
    logic [1:0] m_pal  [8];
    logic       m_prio [8];
    logic       m_flip [8];
    int         m_wait [8];   // dots still to skip before the first pixel
    int         m_done [8];   // pixels already emitted (8 = exhausted)

    function automatic vec_t mk(input logic r, input logic c, input logic l,
                                input logic [2:0] s, input logic [7:0] lo,
                                input logic [7:0] hi, input logic [7:0] a,
                                input logic [7:0] x, input logic p,
                                input logic ac, input logic [2:0] w,
                                input logic [3:0] ep, input logic [7:0] epr);
        vec_t v;
        v.rst = r; v.clr = c; v.ld = l; v.slot = s; v.lo = lo; v.hi = hi;
        v.attr = a; v.x = x; v.pix = p; v.act = ac; v.wslot = w;
        v.exp_pix = ep; v.exp_prio = epr;
        return v;
    endfunction

    task automatic model_empty(input int i);
        m_lo[i] = 8'h00; m_hi[i] = 8'h00; m_pal[i] = 2'b00; m_prio[i] = 1'b1;
        m_flip[i] = 1'b0; m_wait[i] = 0; m_done[i] = 0;
    endtask

    task automatic model_step(input vec_t v);
        for (int i = 0; i < 8; i++) begin
            if (v.rst) begin
                model_empty(i);
            end else if (v.ld && v.slot == 3'(i)) begin
                m_lo[i] = v.lo; m_hi[i] = v.hi; m_pal[i] = v.attr[1:0];
                m_prio[i] = v.attr[5]; m_flip[i] = v.attr[6];
                m_wait[i] = int'(v.x); m_done[i] = 0;
            end else if (v.clr) begin
                model_empty(i);
            end else if (v.pix && v.act) begin
                if (m_wait[i] > 0)      m_wait[i]--;
                else if (m_done[i] < 8) m_done[i]++;
            end
        end
    endtask

    function automatic logic [3:0] model_pixel(input int i);
        int b;
        if (m_wait[i] != 0) return 4'h0;
        if (m_done[i] >= 8) return {m_pal[i], 2'b00};
        // Leftmost pixel is bit 7, or bit 0 when flipped.
        b = m_flip[i] ? m_done[i] : 7 - m_done[i];
        return {m_pal[i], m_hi[i][b], m_lo[i][b]};
    endfunction

    function automatic logic [31:0] model_pix_vec();
        logic [31:0] r;
        for (int i = 0; i < 8; i++) r[i*4 +: 4] = model_pixel(i);
        return r;
    endfunction

    function automatic logic [7:0] model_prio_vec();
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = m_prio[i];
        return r;
    endfunction

    function automatic logic [31:0] dut_pix_vec();
        logic [31:0] r;
        for (int i = 0; i < 8; i++) r[i*4 +: 4] = px[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [39:0] got,
                         input logic [39:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    // Drive one clock of stimulus, advance the model, compare after the edge.
    task automatic cycle(input string tag, input vec_t v);
        rst = v.rst; clear_all = v.clr; load_en = v.ld; load_slot = v.slot;
        load_pat_lo = v.lo; load_pat_hi = v.hi; load_attr = v.attr;
        load_x = v.x; pix_en = v.pix; shift_active = v.act;
        @(posedge clk);
        model_step(v);
        #1;
        check({tag, " pixels"}, 40'(dut_pix_vec()), 40'(model_pix_vec()));
        check({tag, " prio"}, 40'(prio_buff), 40'(model_prio_vec()));
        $display("%s: rst=%0d clr=%0d ld=%0d slot=%0d pix=%0d act=%0d -> pix=%h prio=%h",
                 tag, v.rst, v.clr, v.ld, v.slot, v.pix, v.act, dut_pix_vec(), prio_buff);
    endtask

    vec_t tbl[$];
    vec_t idle;
    vec_t sh;
    logic [31:0] prev_pix;
    logic [7:0]  prev_prio;

    initial begin
        rst = 1'b1; pix_en = 1'b0; shift_active = 1'b0; clear_all = 1'b0;
        load_en = 1'b0; load_slot = 3'd0; load_pat_lo = 8'h00;
        load_pat_hi = 8'h00; load_attr = 8'h00; load_x = 8'h00;
        for (int i = 0; i < 8; i++) model_empty(i);

        idle = mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,0,0,0,4'h0,8'hFF);
        sh   = mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,1,1,0,4'h0,8'hFF);

        // Reset, with a load and clear attempted on top of it.
        cycle("reset0", mk(1,0,0,0,8'h00,8'h00,8'h00,8'h00,0,0,0,4'h0,8'hFF));
        cycle("reset1", mk(1,1,1,4,8'hFF,8'hFF,8'h03,8'h00,1,1,0,4'h0,8'hFF));
        check("reset pixels", 40'(dut_pix_vec()), 40'h0);
        check("reset prio", 40'(prio_buff), 40'hFF);

        // Slot 0: F0/0F, palette 2, X=0
        tbl.push_back(mk(0,1,0,0,8'h00,8'h00,8'h00,8'h00,0,0,0,4'h0,8'hFF));
        tbl.push_back(mk(0,0,1,0,8'hF0,8'h0F,8'h02,8'h00,0,0,0,4'h9,8'hFE));
        tbl.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,1,1,0,4'h9,8'hFE));
        tbl.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,1,1,0,4'h9,8'hFE));
        tbl.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,1,0,0,4'h9,8'hFE));
        tbl.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,0,1,0,4'h9,8'hFE));
        tbl.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,1,1,0,4'h9,8'hFE));
        tbl.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,1,1,0,4'hA,8'hFE));
        tbl.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,1,1,0,4'hA,8'hFE));
        tbl.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,1,1,0,4'hA,8'hFE));
        tbl.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,1,1,0,4'hA,8'hFE));
        tbl.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,1,1,0,4'h8,8'hFE));
        tbl.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,1,1,0,4'h8,8'hFE));
        // Slot 3: single pixel at X=5
        tbl.push_back(mk(0,1,0,0,8'h00,8'h00,8'h00,8'h00,0,0,3,4'h0,8'hFF));
        tbl.push_back(mk(0,0,1,3,8'h80,8'h00,8'h00,8'h05,0,0,3,4'h0,8'hF7));
        tbl.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,1,1,3,4'h0,8'hF7));
        tbl.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,1,1,3,4'h0,8'hF7));
        tbl.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,1,1,3,4'h0,8'hF7));
        tbl.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,1,1,3,4'h0,8'hF7));
        tbl.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,1,1,3,4'h1,8'hF7));
        tbl.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,1,1,3,4'h0,8'hF7));
        // Slot 7: horizontal flip
        tbl.push_back(mk(0,1,0,0,8'h00,8'h00,8'h00,8'h00,0,0,7,4'h0,8'hFF));
        tbl.push_back(mk(0,0,1,7,8'h01,8'h00,8'h40,8'h00,0,0,7,4'h1,8'h7F));
        tbl.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,1,1,7,4'h0,8'h7F));
        // Slot 2: priority bit
        tbl.push_back(mk(0,1,0,0,8'h00,8'h00,8'h00,8'h00,0,0,2,4'h0,8'hFF));
        tbl.push_back(mk(0,0,1,2,8'h00,8'h00,8'h20,8'h00,0,0,2,4'h0,8'hFF));
        tbl.push_back(mk(0,0,1,2,8'h00,8'h00,8'h00,8'h00,0,0,2,4'h0,8'hFB));
        tbl.push_back(mk(0,1,0,0,8'h00,8'h00,8'h00,8'h00,0,0,2,4'h0,8'hFF));
        // Same-cycle clear + load: slot 1 survives, slot 4 is emptied
        tbl.push_back(mk(0,0,1,4,8'hFF,8'h00,8'h03,8'h00,0,0,4,4'hD,8'hEF));
        tbl.push_back(mk(0,1,1,1,8'hFF,8'h00,8'h01,8'h00,0,0,1,4'h5,8'hFD));
        tbl.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,8'h00,0,0,4,4'h0,8'hFD));

        foreach (tbl[i]) begin
            cycle($sformatf("vec%0d", i), tbl[i]);
            check($sformatf("vec%0d slot%0d", i, tbl[i].wslot),
                  40'(px[tbl[i].wslot]), 40'(tbl[i].exp_pix));
            check($sformatf("vec%0d prio_buff", i),
                  40'(prio_buff), 40'(tbl[i].exp_prio));
        end

        // Load during a shifting strobe: the load wins for that slot.
        cycle("ld_vs_shift", mk(0,0,1,0,8'h80,8'h80,8'h01,8'h00,1,1,0,4'h0,8'hFF));
        check("ld_vs_shift slot0", 40'(px[0]), 40'h7);

        // pix_en every third clock with shift_active held high.
        cycle("slow_ld", mk(0,0,1,0,8'hAA,8'h55,8'h01,8'h02,0,0,0,4'h0,8'hFF));
        for (int c = 0; c < 15; c++) begin
            prev_pix  = dut_pix_vec();
            prev_prio = prio_buff;
            sh.pix = (c % 3 == 0);
            sh.act = 1'b1;
            cycle($sformatf("slow%0d", c), sh);
            if (!sh.pix) begin
                check($sformatf("slow%0d hold", c), 40'(dut_pix_vec()), 40'(prev_pix));
                check($sformatf("slow%0d hold prio", c), 40'(prio_buff), 40'(prev_prio));
            end
        end
        // Reset mid-line, overriding a load and a clear.
        cycle("midrst", mk(1,1,1,0,8'hFF,8'hFF,8'h03,8'h00,1,1,0,4'h0,8'hFF));
        check("midrst pixels", 40'(dut_pix_vec()), 40'h0);
        check("midrst prio", 40'(prio_buff), 40'hFF);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            vec_t v;
            v = idle;
            v.rst  = ($urandom_range(0, 99) == 0);
            v.clr  = ($urandom_range(0, 29) == 0);
            v.ld   = ($urandom_range(0, 3) == 0);
            v.slot = 3'($urandom_range(0, 7));
            v.lo   = 8'($urandom);
            v.hi   = 8'($urandom);
            v.attr = 8'($urandom);
            v.x    = 8'($urandom_range(0, 12));
            v.pix  = ($urandom_range(0, 1) == 1);
            v.act  = ($urandom_range(0, 4) != 0);
            cycle($sformatf("rnd%0d", n), v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_shifter.md
SPRITE_SHIFTER -- requirements
Module: sprite_shifter

Interface
REQ-001 The block SHALL have no parameters; slot count is fixed at 8.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pix_en  input  1  one-cycle dot strobe, one per PPU dot.
REQ-005 shift_active  input  1  high during visible dots 0..255 of a rendered line.
REQ-006 clear_all  input  1  one-cycle strobe that empties all slots before a load phase.
REQ-007 load_en  input  1  one-cycle write strobe for one slot.
REQ-008 load_slot  input  3  slot index 0..7 written by load_en.
REQ-009 load_pat_lo / load_pat_hi  input  8 each  pattern bitplanes 0 and 1, bit 7 = leftmost pixel.
REQ-010 load_attr  input  8  OAM attribute byte: [1:0] palette, [5] priority (1 = behind background), [6] hflip.
REQ-011 load_x  input  8  sprite X position.
REQ-012 sprite_pixel_0 .. sprite_pixel_7  output  4 each  {palette[1:0], plane1 bit, plane0 bit} of slot N; lower 2 bits 00 = transparent.
REQ-013 sprite_priority_buff  output  8  bit N = priority bit of slot N.

Function
REQ-014 Each slot SHALL hold pat_lo[7:0], pat_hi[7:0], pal[1:0], prio, and x_cnt[7:0].
REQ-015 load_en SHALL write slot load_slot on the next edge: x_cnt=load_x, pal=load_attr[1:0], prio=load_attr[5].
REQ-016 If load_attr[6]=1, pattern bytes SHALL be stored bit-reversed (bit 0 to bit 7); otherwise stored unchanged.
REQ-017 clear_all SHALL zero pat_lo, pat_hi, pal and x_cnt of every slot and set every prio to 1.
REQ-018 If clear_all and load_en occur in the same cycle, the load SHALL win for load_slot; all other slots SHALL clear.
REQ-019 On pix_en=1 with shift_active=1, a slot with x_cnt!=0 SHALL decrement x_cnt by 1 and hold its pattern.
REQ-020 On pix_en=1 with shift_active=1, a slot with x_cnt==0 SHALL shift pat_lo and pat_hi left by one, filling with 0.
REQ-021 x_cnt SHALL saturate at 0 and never wrap.
REQ-022 When pix_en=0 or shift_active=0, counters and patterns SHALL hold.
REQ-023 A load to a slot in the same cycle as its shift/decrement SHALL take priority; the shift for that slot is discarded.
REQ-024 sprite_pixel_N SHALL be {pal, pat_hi[7], pat_lo[7]} when x_cnt==0, else 4'b0000; this is combinational from slot registers with zero added latency.
REQ-025 sprite_priority_buff[N] SHALL equal prio of slot N at all times, regardless of x_cnt.
REQ-026 After 8 shifts, a slot SHALL output transparent (lower bits 00) until reloaded.
REQ-027 A sprite loaded with X=k SHALL present its leftmost pixel during the dot-k strobe, with dot 0 counted as the first strobe after shift_active rises.

Reset
REQ-028 While rst=1, all slot patterns, palettes and counters SHALL be 0 and all prio SHALL be 1; rst SHALL override load_en and clear_all.
REQ-029 Out of reset, all sprite_pixel_N SHALL be 4'b0000 and sprite_priority_buff SHALL be 8'hFF.

Structure
REQ-030 A shared PPU package SHALL define the slot count (8) and the attribute bit positions (palette [1:0], priority 5, hflip 6).
REQ-031 One slot SHALL be a sub-module named sprite_slot, instantiated 8 times with a per-instance load select.

Verification
REQ-032 Load slot 0 with lo=8'hF0, hi=8'h0F, attr=8'h02, X=0, then run 8 shifting strobes -> pixel_0 = 4'h9,9,9,9,A,A,A,A, then 4'h8.
REQ-033 Load slot 3 with lo=8'h80, hi=0, attr=0, X=5 -> pixel_3=0 for strobes 0..4, 4'h1 at strobe 5, 4'h0 at strobe 6.
REQ-034 Load slot 7 with lo=8'h01, attr=8'h40 (hflip), X=0 -> pixel_7=4'h1 on the first strobe, then 0.
REQ-035 Load slot 2 with attr=8'h20 -> priority_buff=8'hFF; load with attr=8'h00 -> priority_buff=8'hFB; clear_all -> 8'hFF.
REQ-036 Hold shift_active=1 and pulse pix_en every 3rd clock -> state changes only on pix_en cycles; assert rst mid-line -> all outputs at reset values on the next edge.
REQ-037 Assert clear_all and load_en (slot 1, lo=8'hFF, attr=8'h01, X=0) in the same cycle -> pixel_1=4'h5, all other pixels 0.
